// File: rtl/lsq_pkg.sv
// Shared types and helpers for the LSQ memory-access stage.
package lsq_pkg;

    localparam int LSQ_PC_WIDTH   = 12;
    localparam int LSQ_ADDR_WIDTH = 32;
    localparam int LSQ_DATA_WIDTH = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WB} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    typedef struct packed {
        logic                      is_load;
        logic [2:0]                funct3;
        logic [LSQ_PC_WIDTH-1:0]   pc;
        logic [LSQ_ADDR_WIDTH-1:0] address;
        logic [LSQ_DATA_WIDTH-1:0] data;
    } lsq_entry_t;

    // Unused encodings (011, 110, 111) fall through to word size.
    function automatic size_t f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3_size(f3))
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsq_mem_stage_load_aligner.sv
// Combinational load data alignment and sign/zero extension; also usable for
// a future store-to-load forwarding path.
module load_aligner
    import lsq_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unsigned;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = i_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_byte     = w_lane[i_addr_lo];
    assign w_half     = i_addr_lo[1] ? {w_lane[3], w_lane[2]} : {w_lane[1], w_lane[0]};
    assign w_unsigned = i_funct3[2];

    always_comb begin
        o_result = i_rdata;
        case (f3_size(i_funct3))
            SZ_B:    o_result = w_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    o_result = w_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsq_mem_stage.sv
// Memory-access stage behind the LSQ: one entry at a time, req/ack memory port,
// aligned load writeback tagged by PC, and misalignment reported via writeback.
module lsq_mem_stage
    import lsq_pkg::*;
#(
    parameter int PC_WIDTH   = 12,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lsq_valid,
    output logic                  lsq_ready,
    input  logic                  lsq_is_load,
    input  logic [2:0]            lsq_funct3,
    input  logic [PC_WIDTH-1:0]   lsq_pc,
    input  logic [ADDR_WIDTH-1:0] lsq_address,
    input  logic [DATA_WIDTH-1:0] lsq_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [PC_WIDTH-1:0]   wb_pc,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_misaligned,
    output logic                  store_done
);

    state_t                r_state;
    logic                  r_lsq_ready;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [3:0]            r_mem_be;
    logic                  r_wb_valid;
    logic [PC_WIDTH-1:0]   r_wb_pc;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_wb_misaligned;
    logic                  r_store_done;
    logic                  r_is_load;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [1:0]            r_addr_lo;
    logic [2:0]            r_funct3;

    logic                  w_misaligned;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_load_result;

    assign w_misaligned = is_misaligned(lsq_funct3, lsq_address[1:0]);

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = lsq_data;
        case (f3_size(lsq_funct3))
            SZ_B: begin
                w_be    = 4'b0001 << lsq_address[1:0];
                w_wdata = {4{lsq_data[7:0]}};
            end
            SZ_H: begin
                w_be    = 4'b0011 << lsq_address[1:0];
                w_wdata = {2{lsq_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = lsq_data;
            end
        endcase
    end

    load_aligner u_load_aligner (
        .i_rdata   (mem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_result  (w_load_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_lsq_ready     <= 1'b1;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_mem_be        <= 4'b0000;
            r_wb_valid      <= 1'b0;
            r_wb_pc         <= '0;
            r_wb_data       <= '0;
            r_wb_misaligned <= 1'b0;
            r_store_done    <= 1'b0;
            r_is_load       <= 1'b0;
            r_pc            <= '0;
            r_addr_lo       <= 2'b00;
            r_funct3        <= 3'b000;
        end else begin
            r_store_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (lsq_valid) begin
                        r_lsq_ready <= 1'b0;
                        r_is_load   <= lsq_is_load;
                        r_pc        <= lsq_pc;
                        r_addr_lo   <= lsq_address[1:0];
                        r_funct3    <= lsq_funct3;
                        if (w_misaligned) begin
                            r_state         <= WB;
                            r_wb_valid      <= 1'b1;
                            r_wb_pc         <= lsq_pc;
                            r_wb_data       <= '0;
                            r_wb_misaligned <= 1'b1;
                        end else begin
                            r_state     <= REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= ~lsq_is_load;
                            r_mem_addr  <= {lsq_address[ADDR_WIDTH-1:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                            r_mem_be    <= lsq_is_load ? 4'b1111 : w_be;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_is_load) begin
                            r_state         <= WB;
                            r_wb_valid      <= 1'b1;
                            r_wb_pc         <= r_pc;
                            r_wb_data       <= w_load_result;
                            r_wb_misaligned <= 1'b0;
                        end else begin
                            r_state      <= IDLE;
                            r_store_done <= 1'b1;
                            r_lsq_ready  <= 1'b1;
                        end
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        r_state     <= IDLE;
                        r_wb_valid  <= 1'b0;
                        r_lsq_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_lsq_ready <= 1'b1;
                end
            endcase
        end
    end

    assign lsq_ready     = r_lsq_ready;
    assign mem_req       = r_mem_req;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_be        = r_mem_be;
    assign wb_valid      = r_wb_valid;
    assign wb_pc         = r_wb_pc;
    assign wb_data       = r_wb_data;
    assign wb_misaligned = r_wb_misaligned;
    assign store_done    = r_store_done;

endmodule

// File: tb/tb_lsq_mem_stage.sv
// Directed bench for lsq_mem_stage: a vector table of single accesses plus
// hand-written sequences for delayed ack, writeback stall and reset mid-access.
module tb_lsq_mem_stage;
    import lsq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsq_valid;
    logic        lsq_ready;
    logic        lsq_is_load;
    logic [2:0]  lsq_funct3;
    logic [11:0] lsq_pc;
    logic [31:0] lsq_address;
    logic [31:0] lsq_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [11:0] wb_pc;
    logic [31:0] wb_data;
    logic        wb_misaligned;
    logic        store_done;

    always #5 clk = ~clk;

    lsq_mem_stage #(.PC_WIDTH(12), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .lsq_valid     (lsq_valid),
        .lsq_ready     (lsq_ready),
        .lsq_is_load   (lsq_is_load),
        .lsq_funct3    (lsq_funct3),
        .lsq_pc        (lsq_pc),
        .lsq_address   (lsq_address),
        .lsq_data      (lsq_data),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_pc         (wb_pc),
        .wb_data       (wb_data),
        .wb_misaligned (wb_misaligned),
        .store_done    (store_done)
    );

    typedef struct {
        logic        is_load;
        logic [2:0]  f3;
        logic [11:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic        exp_mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic present(input logic is_load, input logic [2:0] f3, input logic [11:0] pc,
                           input logic [31:0] addr, input logic [31:0] data);
        lsq_valid   = 1'b1;
        lsq_is_load = is_load;
        lsq_funct3  = f3;
        lsq_pc      = pc;
        lsq_address = addr;
        lsq_data    = data;
    endtask

    // Cycle 0 = accept, cycle 1 = REQ (ack immediately) or WB for misaligned.
    task automatic run_vec(input vec_t v, input int idx);
        tick();
        check("ready_idle", 32'(lsq_ready), 32'd1);
        present(v.is_load, v.f3, v.pc, v.addr, v.data);
        tick();
        lsq_valid = 1'b0;
        if (v.exp_mis) begin
            check("mis_wb_valid", 32'(wb_valid), 32'd1);
            check("mis_flag", 32'(wb_misaligned), 32'd1);
            check("mis_wb_data", wb_data, 32'd0);
            check("mis_wb_pc", 32'(wb_pc), 32'(v.pc));
            check("mis_no_req", 32'(mem_req), 32'd0);
            wb_ready = 1'b1;
            tick();
            wb_ready = 1'b0;
            check("mis_wb_drop", 32'(wb_valid), 32'd0);
            check("mis_ready_back", 32'(lsq_ready), 32'd1);
            check("mis_no_req_after", 32'(mem_req), 32'd0);
        end else begin
            check("req_c1", 32'(mem_req), 32'd1);
            check("req_we", 32'(mem_we), 32'(!v.is_load));
            check("req_addr", mem_addr, v.exp_addr);
            check("req_be", 32'(mem_be), 32'(v.exp_be));
            if (!v.is_load) check("req_wdata", mem_wdata, v.exp_wdata);
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            check("req_drop", 32'(mem_req), 32'd0);
            if (v.is_load) begin
                check("ld_wb_valid", 32'(wb_valid), 32'd1);
                check("ld_wb_data", wb_data, v.exp_wb);
                check("ld_wb_pc", 32'(wb_pc), 32'(v.pc));
                check("ld_wb_mis", 32'(wb_misaligned), 32'd0);
                check("ld_ready_wb", 32'(lsq_ready), 32'd0);
                wb_ready = 1'b1;
                tick();
                wb_ready = 1'b0;
                check("ld_wb_drop", 32'(wb_valid), 32'd0);
                check("ld_ready_back", 32'(lsq_ready), 32'd1);
            end else begin
                check("st_done", 32'(store_done), 32'd1);
                check("st_ready", 32'(lsq_ready), 32'd1);
                check("st_no_wb", 32'(wb_valid), 32'd0);
                tick();
                check("st_done_pulse", 32'(store_done), 32'd0);
            end
        end
        $display("txn %0d: %s f3=%03b pc=0x%03h addr=0x%08h wb_data=0x%08h mis=%0b",
                 idx, v.is_load ? "LOAD " : "STORE", v.f3, v.pc, v.addr, wb_data, wb_misaligned);
    endtask

    initial begin
        //           ld    f3     pc      addr          data          rdata         mis   exp_addr      be       wdata         wb
        vecs[0]  = '{1'b1, F3_W,  12'h011, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, F3_B,  12'h012, 32'h0000_0103, 32'h0,        32'h8011_2233, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b1, F3_BU, 12'h013, 32'h0000_0103, 32'h0,        32'h8011_2233, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b1, F3_H,  12'h014, 32'h0000_0102, 32'h0,        32'h8011_2233, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_8011};
        vecs[4]  = '{1'b1, F3_HU, 12'h015, 32'h0000_0102, 32'h0,        32'h8011_2233, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_8011};
        vecs[5]  = '{1'b1, F3_B,  12'h016, 32'h0000_0101, 32'h0,        32'h8011_2233, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_0022};
        vecs[6]  = '{1'b1, F3_H,  12'h017, 32'h0000_0200, 32'h0,        32'h1234_F00D, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,        32'hFFFF_F00D};
        vecs[7]  = '{1'b1, 3'b011, 12'h018, 32'h0000_0300, 32'h0,       32'hCAFE_F00D, 1'b0, 32'h0000_0300, 4'b1111, 32'h0,        32'hCAFE_F00D};
        vecs[8]  = '{1'b0, F3_B,  12'h021, 32'h0000_0401, 32'h0000_00A5, 32'h0,        1'b0, 32'h0000_0400, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[9]  = '{1'b0, F3_H,  12'h022, 32'h0000_0202, 32'h0000_ABCD, 32'h0,        1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[10] = '{1'b0, F3_W,  12'h023, 32'h0000_040C, 32'h1234_5678, 32'h0,        1'b0, 32'h0000_040C, 4'b1111, 32'h1234_5678, 32'h0};
        vecs[11] = '{1'b1, F3_W,  12'h031, 32'h0000_0102, 32'h0,        32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1'b0, F3_H,  12'h032, 32'h0000_0203, 32'h0000_1111, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1'b1, F3_H,  12'h033, 32'h0000_0101, 32'h0,        32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[14] = '{1'b1, F3_BU, 12'h034, 32'h0000_0004, 32'h0,        32'h0000_00FF, 1'b0, 32'h0000_0004, 4'b1111, 32'h0,        32'h0000_00FF};
        vecs[15] = '{1'b1, 3'b111, 12'h035, 32'h0000_0006, 32'h0,       32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};

        reset       = 1'b1;
        lsq_valid   = 1'b0;
        lsq_is_load = 1'b0;
        lsq_funct3  = 3'b000;
        lsq_pc      = 12'h0;
        lsq_address = 32'h0;
        lsq_data    = 32'h0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        wb_ready    = 1'b0;

        tick();
        tick();
        check("rst_lsq_ready", 32'(lsq_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_pc", 32'(wb_pc), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_mis", 32'(wb_misaligned), 32'd0);
        check("rst_store_done", 32'(store_done), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        // SH with ack three cycles late: request must hold steady throughout.
        tick();
        present(1'b0, F3_H, 12'h041, 32'h0000_0202, 32'h0000_ABCD);
        tick();
        lsq_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("dly_req", 32'(mem_req), 32'd1);
            check("dly_we", 32'(mem_we), 32'd1);
            check("dly_addr", mem_addr, 32'h0000_0200);
            check("dly_be", 32'(mem_be), 32'b1100);
            check("dly_wdata", mem_wdata, 32'hABCD_ABCD);
            check("dly_no_done", 32'(store_done), 32'd0);
            check("dly_no_wb", 32'(wb_valid), 32'd0);
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check("dly_done", 32'(store_done), 32'd1);
        check("dly_ready", 32'(lsq_ready), 32'd1);
        check("dly_req_drop", 32'(mem_req), 32'd0);
        tick();
        check("dly_done_once", 32'(store_done), 32'd0);
        check("dly_no_wb_end", 32'(wb_valid), 32'd0);
        $display("txn delayed-ack SH: store_done pulse observed, addr=0x%08h be=%04b", mem_addr, mem_be);

        // Writeback stalled 4 cycles while the next entry waits with lsq_valid high.
        present(1'b1, F3_W, 12'h0AA, 32'h0000_0500, 32'h0);
        tick();
        present(1'b1, F3_W, 12'h0BB, 32'h0000_0504, 32'h0);
        check("stl_ready_req", 32'(lsq_ready), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_CAFE;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check("stl_wb_valid", 32'(wb_valid), 32'd1);
            check("stl_wb_pc", 32'(wb_pc), 32'h0AA);
            check("stl_wb_data", wb_data, 32'h0BAD_CAFE);
            check("stl_ready_low", 32'(lsq_ready), 32'd0);
            check("stl_no_req", 32'(mem_req), 32'd0);
            if (i == 4) wb_ready = 1'b1;
            tick();
        end
        wb_ready = 1'b0;
        check("stl_ready_back", 32'(lsq_ready), 32'd1);
        check("stl_wb_drop", 32'(wb_valid), 32'd0);
        tick();
        lsq_valid = 1'b0;
        check("stl_next_req", 32'(mem_req), 32'd1);
        check("stl_next_addr", mem_addr, 32'h0000_0504);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check("stl_next_wb_pc", 32'(wb_pc), 32'h0BB);
        check("stl_next_wb_data", wb_data, 32'h1111_2222);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("stl_next_done", 32'(wb_valid), 32'd0);
        $display("txn wb-stall: second entry pc=0x%03h data=0x%08h", wb_pc, wb_data);

        // Reset during REQ abandons the entry; a late ack must be ignored.
        for (int k = 0; k < 2; k++) begin
            tick();
            present(k == 0, F3_W, 12'h0CC, 32'h0000_0600, 32'h5555_AAAA);
            tick();
            lsq_valid = 1'b0;
            check("rq_req_high", 32'(mem_req), 32'd1);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check("rq_req_drop", 32'(mem_req), 32'd0);
            check("rq_ready", 32'(lsq_ready), 32'd1);
            mem_ack   = 1'b1;
            mem_rdata = 32'hFEED_FACE;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            check("rq_late_no_wb", 32'(wb_valid), 32'd0);
            check("rq_late_no_done", 32'(store_done), 32'd0);
            check("rq_late_no_req", 32'(mem_req), 32'd0);
            check("rq_late_ready", 32'(lsq_ready), 32'd1);
            tick();
            check("rq_quiet_wb", 32'(wb_valid), 32'd0);
            check("rq_quiet_done", 32'(store_done), 32'd0);
            $display("txn reset-in-REQ (%s): late ack ignored", k == 0 ? "load" : "store");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsq_mem_stage.md
# lsq_mem_stage

Memory-access stage directly downstream of the LSQ. Pops one entry at a time from the LSQ head over a valid/ready handshake and performs the access on a variable-latency data-memory port (req/ack). Stores use byte enables. Loads return an aligned, sign- or zero-extended result on a writeback handshake toward the CDB/ROB, tagged by PC.

## Interface
Parameters:
- PC_WIDTH, 12, width of the PC tag carried with each entry
- ADDR_WIDTH, 32, memory address width
- DATA_WIDTH, 32, data-word width; fixed at 32, byte-lane logic assumes 4 lanes

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- lsq_valid  in  1  LSQ head entry present
- lsq_ready  out  1  stage accepts entry this cycle
- lsq_is_load  in  1  1 = load, 0 = store
- lsq_funct3  in  3  size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
- lsq_pc  in  PC_WIDTH  tag of the entry
- lsq_address  in  ADDR_WIDTH  byte address
- lsq_data  in  DATA_WIDTH  store data, right-aligned
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  DATA_WIDTH  store data shifted to lane
- mem_be  out  4  byte enables (all 1 for reads)
- mem_ack  in  1  request completed; mem_rdata valid same cycle for reads
- mem_rdata  in  DATA_WIDTH  read word
- wb_valid  out  1  load result or exception available
- wb_ready  in  1  consumer takes result
- wb_pc  out  PC_WIDTH  tag of result
- wb_data  out  DATA_WIDTH  extended load data (0 on exception)
- wb_misaligned  out  1  access was misaligned; no memory op done
- store_done  out  1  one-cycle pulse when a store is acknowledged

## Operation
FSM states and transitions:
- IDLE: lsq_ready=1. On lsq_valid, latch entry, then:
  - misaligned → WB with wb_misaligned=1
  - otherwise → REQ
- REQ: mem_req=1. mem_we, mem_addr, mem_wdata and mem_be are held stable until mem_ack is sampled high.
  - Ack on a load: latch the extended rdata, → WB.
  - Ack on a store: → IDLE, with store_done pulsed in the following cycle.
- WB: wb_valid=1 with wb_pc, wb_data and wb_misaligned held stable until wb_ready is sampled high, then → IDLE.

Misalignment rules:
- Halfword access with addr[0]=1 is misaligned.
- Word access with addr[1:0]≠00 is misaligned.
- Misaligned stores also go to WB with wb_misaligned=1, so the ROB sees the exception.
- Invalid funct3 values (011, 110, 111) are treated as word accesses.

Store lane steering:
- byte: be = 0001 << addr[1:0]; wdata = {4{data[7:0]}}
- half: be = 0011 << addr[1:0]; wdata = {2{data[15:0]}}
- word: be = 1111; wdata = data

Load extraction:
- Select the byte or half from rdata by addr[1:0].
- Sign-extend for LB/LH; zero-extend for LBU/LHU.

Other rules:
- mem_ack outside REQ is ignored.
- Only one outstanding access exists at a time; ordering is strictly LSQ order.

## Timing
- Reset values:
  - State = IDLE.
  - lsq_ready=1; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - wb_valid=0, wb_pc=0, wb_data=0, wb_misaligned=0, store_done=0.
- Reset asserted mid-access (REQ or WB) abandons the entry: next cycle is IDLE with mem_req=0. The memory must tolerate a dropped request.
- lsq_ready is a registered, state-decoded output. It does not depend combinationally on lsq_valid.
- Accept happens in cycle 0 (valid & ready). mem_req is first high in cycle 1.
- If mem_ack arrives in cycle k:
  - load: wb_valid is high from cycle k+1
  - store: store_done is high in cycle k+1, and lsq_ready is 1 in cycle k+1
- Best-case throughput:
  - stores: one per 2 cycles
  - loads: one per 3 cycles when wb_ready is held high
- Misaligned entry: wb_valid is high in cycle 1 and mem_req never rises.
- A wb_ready held low stalls the stage indefinitely. The output stays stable and lsq_ready stays 0.

## Structure
- Shared package lsq_pkg holds:
  - lsq_entry_t, extended with funct3
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the state enum {IDLE, REQ, WB}
- Sub-module load_aligner, purely combinational: (rdata, addr[1:0], funct3) → extended 32-bit result. It is reusable by a later store-to-load forwarding path.

## Test plan
- Reset, then LW at 0x100 with rdata=0xDEADBEEF and ack on the first REQ cycle → mem_req in cycle 1, mem_be=1111, wb_valid in cycle 2, wb_data=0xDEADBEEF, wb_pc = the entry's PC.
- LB at 0x103 with rdata=0x80112233 → wb_data=0xFFFFFF80. The same access as LBU → 0x00000080.
- SH data=0x0000ABCD at 0x202, ack delayed 3 cycles → mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD, outputs stable while waiting, store_done pulses once, no wb_valid.
- LW at 0x102 → wb_misaligned=1 in cycle 1, mem_req stays 0, wb_data=0.
- Load completes with wb_ready low for 4 cycles while lsq_valid stays high → wb outputs stable, lsq_ready=0, next entry accepted the cycle after wb_ready=1.
- Reset asserted during REQ → next cycle mem_req=0, lsq_ready=1. A late mem_ack is ignored, with no wb_valid and no store_done.
